// File: rtl/timer_dev_pkg.sv
// Shared definitions for the memory-mapped countdown timer.
// Latency: n/a (constants, types and a combinational helper only).
// Backpressure: n/a.
package timer_dev_pkg;

    // Register offsets decoded from addr[3:2]; offset 3 is reserved.
    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;

    // CTRL bit positions.
    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    // MODE codes; 10/11 behave like one-shot.
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_AUTO    = 2'b01;

    localparam logic [31:0] CTRL_MASK_DEFAULT = 32'h0000_000F;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    // Replace each enabled byte lane of old_val with the matching lane of new_val.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/timer_dev.sv
// Countdown timer with CTRL/PRESET/COUNT registers, one-shot or auto-reload, masked irq.
// Latency: writes land on the capturing edge; reads are combinational; EN write to COUNT=PRESET is 2 edges.
// Backpressure: none, every bus access completes in one cycle.
module timer_dev
    import timer_dev_pkg::*;
#(
    parameter logic [31:0] CTRL_MASK = CTRL_MASK_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    logic [31:0] ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        irq_flag;
    state_t      state;
    state_t      state_nxt;

    logic [1:0]  reg_off;
    logic        wr_ctrl;
    logic        wr_preset;
    logic        en;
    logic        auto_mode;
    logic        count_zero;

    // FSM-derived strobes driving the datapath
    logic        load_cnt;
    logic        dec_cnt;
    logic        int_fire;
    logic        clr_en;

    // Only addr[3:2] selects a register; the rest of the address is the bridge's business.
    logic        unused_addr;
    assign unused_addr = ^{addr[31:4], addr[1:0]};

    assign reg_off    = addr[3:2];
    assign wr_ctrl    = sel && we && (reg_off == OFF_CTRL);
    assign wr_preset  = sel && we && (reg_off == OFF_PRESET);
    assign en         = ctrl[CTRL_EN];
    assign auto_mode  = (ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_AUTO);
    assign count_zero = (count == 32'd0);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (en) state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = ST_CNT;
            ST_CNT: begin
                if (!en) begin
                    state_nxt = ST_IDLE;
                end else if (count_zero) begin
                    state_nxt = ST_INT;
                end
            end
            ST_INT:  state_nxt = auto_mode ? ST_LOAD : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output decode: per-state datapath strobes
    always_comb begin
        load_cnt = (state == ST_LOAD);
        dec_cnt  = (state == ST_CNT) && en && !count_zero;
        int_fire = (state == ST_INT);
        clr_en   = (state == ST_INT) && !auto_mode;
    end

    // CTRL: a CPU write takes priority over the one-shot EN clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl <= 32'd0;
        end else if (wr_ctrl) begin
            ctrl <= lane_merge(ctrl, wdata, byteen) & CTRL_MASK;
        end else if (clr_en) begin
            ctrl[CTRL_EN] <= 1'b0;
        end
    end

    // PRESET: plain byte-lane writable register, only sampled on LOAD
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            preset <= 32'd0;
        end else if (wr_preset) begin
            preset <= lane_merge(preset, wdata, byteen);
        end
    end

    // COUNT: reload on LOAD, decrement while counting, never below zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= 32'd0;
        end else if (load_cnt) begin
            count <= preset;
        end else if (dec_cnt) begin
            count <= count - 32'd1;
        end
    end

    // irq_flag: register writes clear it and win over INT; in auto-reload the
    // following LOAD drops it again, giving a one-cycle pulse. A sticky one-shot
    // flag can never meet LOAD without a CTRL write re-enabling first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_flag <= 1'b0;
        end else if (wr_ctrl || wr_preset) begin
            irq_flag <= 1'b0;
        end else if (int_fire) begin
            irq_flag <= 1'b1;
        end else if (load_cnt) begin
            irq_flag <= 1'b0;
        end
    end

    // Combinational read mux; idle bus and the reserved offset read as 0
    always_comb begin
        rdata = 32'd0;
        if (sel) begin
            case (reg_off)
                OFF_CTRL:   rdata = ctrl;
                OFF_PRESET: rdata = preset;
                OFF_COUNT:  rdata = count;
                default:    rdata = 32'd0;
            endcase
        end
    end

    assign irq = irq_flag && ctrl[CTRL_IM];

endmodule
